// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port RAM arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Width of the wait counter for a given wait-state count, never below 1 bit.
  function automatic int unsigned wcnt_width(input int unsigned ws);
    return (ws == 0) ? 1 : $clog2(ws + 1);
  endfunction

  // Largest legal wait-state setting and the counter width it needs.
  localparam int unsigned WAIT_STATES_MAX = 7;
  localparam int unsigned WCNT_W          = wcnt_width(WAIT_STATES_MAX);

endpackage

// File: rtl/mem_port_arbiter_wait.sv
// mem_wait_timer: load/decrement wait-state counter with a zero flag.
module mem_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int unsigned W = wcnt_width(WAIT_STATES);

  logic [W-1:0] r_wcnt;

  // Load on issue, count down while the access is in flight, stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (i_load) begin
      r_wcnt <= W'(WAIT_STATES);
    end else if (i_dec && (r_wcnt != '0)) begin
      r_wcnt <= r_wcnt - 1'b1;
    end
  end

  assign o_zero = (r_wcnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction
// fetch and the MEM stage, with configurable wait states and an anti-starvation
// limit on consecutive MEM grants. Optional stall counter: MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MAX_CONSEC  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_done,
  output logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [31:0]   stall_cnt
);

  localparam logic [3:0] CCNT_LIMIT = 4'(MAX_CONSEC);

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  logic [3:0]    r_ccnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic w_grant_mem;
  logic w_grant_if;
  logic w_grant;
  logic w_done;
  logic w_wzero;
  logic w_issue_mem;
  logic w_issue_if;
  logic w_if_done;
  logic w_mem_done;
  logic w_stall_if_raw;
  logic w_stall_mem_raw;

  mem_wait_timer #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_grant),
    .i_dec  (r_state == ST_BUSY),
    .o_zero (w_wzero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant decision in IDLE, completion detection in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req && (!if_req || (r_ccnt < CCNT_LIMIT))) begin
          w_grant_mem = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_wzero) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign w_grant = w_grant_mem | w_grant_if;

  // Capture owner and issued address/data so the RAM bus holds during BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_mem) begin
      r_owner <= OWN_MEM;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
    end else if (w_grant_if) begin
      r_owner <= OWN_IF;
      r_addr  <= if_addr;
      r_wdata <= '0;
    end
  end

  // Consecutive MEM grants counted only while IF is actually waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ccnt <= '0;
    end else if (w_grant_mem && if_req) begin
      if (r_ccnt != 4'hF) begin
        r_ccnt <= r_ccnt + 4'd1;
      end
    end else if (w_grant) begin
      r_ccnt <= '0;
    end
  end

  // rst_n only qualifies the outputs here (never flop inputs), so every output
  // reads 0 while reset is asserted even if requests are pending.
  assign w_issue_mem = w_grant_mem & rst_n;
  assign w_issue_if  = w_grant_if & rst_n;

  assign ram_en    = w_issue_mem | w_issue_if;
  assign ram_we    = w_issue_mem & mem_we;
  assign ram_addr  = w_issue_mem ? mem_addr  : (w_issue_if ? if_addr : r_addr);
  assign ram_wdata = w_issue_mem ? mem_wdata : (w_issue_if ? '0      : r_wdata);

  assign w_if_done  = w_done & (r_owner == OWN_IF);
  assign w_mem_done = w_done & (r_owner == OWN_MEM);
  assign if_done    = w_if_done;
  assign mem_done   = w_mem_done;
  assign if_rdata   = w_if_done  ? ram_rdata : '0;
  assign mem_rdata  = w_mem_done ? ram_rdata : '0;

  assign w_stall_if_raw  = if_req  & ~w_if_done;
  assign w_stall_mem_raw = mem_req & ~w_mem_done;
  assign stall_if        = w_stall_if_raw  & rst_n;
  assign stall_mem       = w_stall_mem_raw & rst_n;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Free-running stall-cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_if_raw | w_stall_mem_raw) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_req, mem_we;
  logic [15:0] if_addr, mem_addr, mem_wdata;
  logic        if_done, mem_done, stall_if, stall_mem, ram_en, ram_we;
  logic [15:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [31:0] stall_cnt;

  logic        z_if_req, z_if_done, z_mem_done, z_stall_if, z_stall_mem;
  logic        z_ram_en, z_ram_we;
  logic [15:0] z_if_addr, z_if_rdata, z_mem_rdata, z_ram_addr, z_ram_wdata, z_ram_rdata;
  logic [31:0] z_stall_cnt;

  logic [15:0] ram [0:1023];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_cnt;
  logic        exp_mem [0:5];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_STATES(1), .MAX_CONSEC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_STATES(0), .MAX_CONSEC(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_done(z_if_done), .if_rdata(z_if_rdata),
    .mem_req(1'b0), .mem_we(1'b0), .mem_addr(16'h0000), .mem_wdata(16'h0000),
    .mem_done(z_mem_done), .mem_rdata(z_mem_rdata),
    .stall_if(z_stall_if), .stall_mem(z_stall_mem),
    .ram_en(z_ram_en), .ram_we(z_ram_we), .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata),
    .ram_rdata(z_ram_rdata), .stall_cnt(z_stall_cnt)
  );

  // Synchronous single-port RAM: read data registered on the access strobe.
  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr[9:0]] <= ram_wdata;
      ram_rdata <= ram[ram_addr[9:0]];
    end
  end

  // Second RAM returns the inverted address as data.
  always_ff @(posedge clk) begin
    if (z_ram_en) z_ram_rdata <= ~z_ram_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
    ram[16'h0010] = 16'hABCD;
    ram_rdata = 16'h0000;
    z_ram_rdata = 16'h0000;
    exp_mem[0] = 1'b1; exp_mem[1] = 1'b1; exp_mem[2] = 1'b1;
    exp_mem[3] = 1'b1; exp_mem[4] = 1'b0; exp_mem[5] = 1'b1;

    // Reset with a pending MEM request: all outputs must read 0.
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 16'h0000;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0055; mem_wdata = 16'h7777;
    z_if_req = 1'b0; z_if_addr = 16'h0000;
    #2;
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_stall_mem", 32'(stall_mem), 32'd0);
    chk("rst_done", 32'({if_done, mem_done}), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    rst_n = 1'b1;

    // IF read of 0x0010.
    tick();
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    chk("if_T_ram_en", 32'(ram_en), 32'd1);
    chk("if_T_ram_addr", 32'(ram_addr), 32'h0010);
    chk("if_T_ram_we", 32'(ram_we), 32'd0);
    chk("if_T_stall", 32'(stall_if), 32'd1);
    tick();
    chk("if_T1_ram_en", 32'(ram_en), 32'd0);
    chk("if_T1_done", 32'(if_done), 32'd0);
    chk("if_T1_stall", 32'(stall_if), 32'd1);
    chk("if_T1_addr_hold", 32'(ram_addr), 32'h0010);
    tick();
    chk("if_T2_done", 32'(if_done), 32'd1);
    chk("if_T2_rdata", 32'(if_rdata), 32'hABCD);
    chk("if_T2_stall", 32'(stall_if), 32'd0);
    tick();
    if_req = 1'b0;
    #1;
    chk("if_T3_ram_en", 32'(ram_en), 32'd0);
    chk("if_T3_rdata0", 32'(if_rdata), 32'd0);

    // MEM write 0x1234 to 0x0200, then read it back.
    tick();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0200; mem_wdata = 16'h1234;
    #1;
    chk("wr_T_ram_en", 32'(ram_en), 32'd1);
    chk("wr_T_ram_we", 32'(ram_we), 32'd1);
    chk("wr_T_wdata", 32'(ram_wdata), 32'h1234);
    chk("wr_T_stall", 32'(stall_mem), 32'd1);
    tick();
    chk("wr_T1_ram_we", 32'(ram_we), 32'd0);
    chk("wr_T1_done", 32'(mem_done), 32'd0);
    chk("wr_T1_wdata_hold", 32'(ram_wdata), 32'h1234);
    tick();
    chk("wr_T2_done", 32'(mem_done), 32'd1);
    chk("wr_T2_stall", 32'(stall_mem), 32'd0);
    tick();
    mem_we = 1'b0;
    #1;
    chk("rd_T3_grant", 32'(ram_en), 32'd1);
    chk("rd_T3_ram_we", 32'(ram_we), 32'd0);
    tick();
    tick();
    chk("rd_done", 32'(mem_done), 32'd1);
    chk("rd_rdata", 32'(mem_rdata), 32'h1234);
    chk("rd_if_rdata0", 32'(if_rdata), 32'd0);
    tick();
    mem_req = 1'b0;

    // Both requesters held: MEM x4, then IF, then MEM.
    if_req = 1'b1; if_addr = 16'h0010;
    mem_req = 1'b1; mem_addr = 16'h0200;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("arb%0d_ram_en", k), 32'(ram_en), 32'd1);
      chk($sformatf("arb%0d_addr", k), 32'(ram_addr), exp_mem[k] ? 32'h0200 : 32'h0010);
      tick();
      tick();
      chk($sformatf("arb%0d_done", k), 32'({mem_done, if_done}),
          exp_mem[k] ? 32'd2 : 32'd1);
      if (k == 4) chk("arb_if_rdata", 32'(if_rdata), 32'hABCD);
      tick();
    end
    if_req = 1'b0; mem_req = 1'b0;

    // WAIT_STATES=0 instance: back-to-back IF fetches every 2 cycles.
    tick();
    z_if_req = 1'b1; z_if_addr = 16'h0033;
    #1;
    chk("ws0_T_ram_en", 32'(z_ram_en), 32'd1);
    tick();
    chk("ws0_T1_done", 32'(z_if_done), 32'd1);
    chk("ws0_T1_rdata", 32'(z_if_rdata), 32'hFFCC);
    chk("ws0_T1_ram_en", 32'(z_ram_en), 32'd0);
    tick();
    chk("ws0_T2_ram_en", 32'(z_ram_en), 32'd1);
    chk("ws0_T2_done", 32'(z_if_done), 32'd0);
    tick();
    chk("ws0_T3_done", 32'(z_if_done), 32'd1);
    z_if_req = 1'b0;

    // Reset dropped mid-access.
    tick();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0300; mem_wdata = 16'h5555;
    #1;
    chk("rb_T_ram_en", 32'(ram_en), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rb_ram_en", 32'(ram_en), 32'd0);
    chk("rb_ram_addr", 32'(ram_addr), 32'd0);
    chk("rb_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rb_stall_mem", 32'(stall_mem), 32'd0);
    chk("rb_done", 32'(mem_done), 32'd0);
    tick();
    chk("rb_done_late", 32'(mem_done), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rb_regrant", 32'(ram_en), 32'd1);
    chk("rb_regrant_addr", 32'(ram_addr), 32'h0300);
    tick();
    chk("rb_T1_ram_en", 32'(ram_en), 32'd0);
    tick();
    chk("rb_done_after", 32'(mem_done), 32'd1);
    tick();
    mem_req = 1'b0; mem_we = 1'b0;

    // Stall counter: five MEM accesses give ten stalled cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mem_req = 1'b1; mem_addr = 16'h0200;
    repeat (15) tick();
    mem_req = 1'b0;
    #1;
`ifdef MEM_ARB_PERF_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    chk("stall_cnt", stall_cnt, exp_cnt);
    chk("stall_cnt_ws0", z_stall_cnt, exp_cnt == 32'd0 ? 32'd0 : 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
